// File: rtl/rv_pipe_hazard_cpu.sv
// rv_pipe_hazard_cpu: five-stage in-order pipeline for an RV subset
// (LD, SD, BEQ, ADDI, ADD/SUB/AND/OR/SLT) with hazard handling.
// BEQ resolves in EX. A taken branch squashes IF/ID and ID/EX.
// Build option RV_PIPE_FWD_EN: when defined, EX gets a forwarding network and
// only a load-use pair stalls. When undefined, ID interlocks on any in-flight
// producer in EX or MEM and relies on WB write-through.
module rv_pipe_hazard_cpu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            stall,
  output logic            flush
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {C_NOP, C_LD, C_SD, C_BEQ, C_ADDI, C_ALU} cls_t;

  // Anything not in the supported subset collapses to C_NOP.
  function automatic cls_t f_cls(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7);
    cls_t c;
    c = C_NOP;
    case (op)
      7'b0000011: if (f3 == 3'b011) c = C_LD;
      7'b0100011: c = C_SD;
      7'b1100011: c = C_BEQ;
      7'b0010011: if (f3 == 3'b000) c = C_ADDI;
      7'b0110011: begin
        if ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 ||
                                  f3 == 3'b110 || f3 == 3'b010)) ||
            (f7 == 7'b0100000 && f3 == 3'b000))
          c = C_ALU;
      end
      default: c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic logic f_writes(input cls_t c);
    return (c == C_LD) || (c == C_ADDI) || (c == C_ALU);
  endfunction

  function automatic logic f_use2(input cls_t c);
    return (c == C_SD) || (c == C_BEQ) || (c == C_ALU);
  endfunction

  // True when an instruction of class c reading rs1/rs2 depends on producer rd.
  function automatic logic f_dep(input cls_t c, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd);
    return (rd != 5'd0) &&
           (((c != C_NOP) && (rs1 == rd)) || (f_use2(c) && (rs2 == rd)));
  endfunction

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ifid_ir, r_idex_ir, r_exmem_ir, r_memwb_ir;
  logic [XLEN-1:0] r_ifid_pc, r_idex_pc;
  logic [XLEN-1:0] r_idex_a, r_idex_b;
  logic [XLEN-1:0] r_exmem_alu, r_exmem_sdata;
  logic [XLEN-1:0] r_memwb_val;
  logic [XLEN-1:0] r_regs [32];

  cls_t            w_id_cls, w_ex_cls, w_mem_cls, w_wb_cls;
  logic [4:0]      w_id_rs1, w_id_rs2, w_ex_rd, w_mem_rd, w_wb_rd;
  logic            w_wb_we;
  logic [XLEN-1:0] w_id_a, w_id_b;
  logic [XLEN-1:0] w_ex_a, w_ex_b, w_ex_res, w_ex_target;
  logic [XLEN-1:0] w_ex_imm_i, w_ex_imm_s, w_ex_imm_b;
  logic [XLEN-1:0] w_mem_val;
  logic            w_hz, w_flush, w_stall;
  logic            w_unused_bits;

  assign w_id_cls  = f_cls(r_ifid_ir[6:0], r_ifid_ir[14:12], r_ifid_ir[31:25]);
  assign w_ex_cls  = f_cls(r_idex_ir[6:0], r_idex_ir[14:12], r_idex_ir[31:25]);
  assign w_mem_cls = f_cls(r_exmem_ir[6:0], r_exmem_ir[14:12], r_exmem_ir[31:25]);
  assign w_wb_cls  = f_cls(r_memwb_ir[6:0], r_memwb_ir[14:12], r_memwb_ir[31:25]);

  assign w_id_rs1 = r_ifid_ir[19:15];
  assign w_id_rs2 = r_ifid_ir[24:20];
  assign w_ex_rd  = r_idex_ir[11:7];
  assign w_mem_rd = r_exmem_ir[11:7];
  assign w_wb_rd  = r_memwb_ir[11:7];
  assign w_wb_we  = f_writes(w_wb_cls) && (w_wb_rd != 5'd0);

  // Only opcode/funct/rd of the WB instruction matter.
  assign w_unused_bits = ^r_memwb_ir[24:15];

  // ID register read with WB write-through; x0 always reads zero.
  always_comb begin
    w_id_a = r_regs[w_id_rs1];
    w_id_b = r_regs[w_id_rs2];
    if (w_id_rs1 == 5'd0) w_id_a = '0;
    else if (w_wb_we && (w_wb_rd == w_id_rs1)) w_id_a = r_memwb_val;
    if (w_id_rs2 == 5'd0) w_id_b = '0;
    else if (w_wb_we && (w_wb_rd == w_id_rs2)) w_id_b = r_memwb_val;
  end

`ifdef RV_PIPE_FWD_EN
  logic [4:0] w_ex_rs1, w_ex_rs2;
  logic       w_mem_fwd;
  assign w_ex_rs1  = r_idex_ir[19:15];
  assign w_ex_rs2  = r_idex_ir[24:20];
  // A load in MEM has no data yet; the load-use stall keeps consumers away.
  assign w_mem_fwd = f_writes(w_mem_cls) && (w_mem_cls != C_LD) && (w_mem_rd != 5'd0);

  // EX operand select: newest producer wins (EX/MEM ALU, then MEM/WB).
  always_comb begin
    w_ex_a = r_idex_a;
    w_ex_b = r_idex_b;
    if (w_mem_fwd && (w_mem_rd == w_ex_rs1)) w_ex_a = r_exmem_alu;
    else if (w_wb_we && (w_wb_rd == w_ex_rs1)) w_ex_a = r_memwb_val;
    if (w_mem_fwd && (w_mem_rd == w_ex_rs2)) w_ex_b = r_exmem_alu;
    else if (w_wb_we && (w_wb_rd == w_ex_rs2)) w_ex_b = r_memwb_val;
  end

  assign w_hz = (w_ex_cls == C_LD) && f_dep(w_id_cls, w_id_rs1, w_id_rs2, w_ex_rd);
`else
  // Operands come straight from ID/EX; the interlock guarantees they are current.
  always_comb begin
    w_ex_a = r_idex_a;
    w_ex_b = r_idex_b;
  end

  assign w_hz = (f_writes(w_ex_cls)  && f_dep(w_id_cls, w_id_rs1, w_id_rs2, w_ex_rd)) ||
                (f_writes(w_mem_cls) && f_dep(w_id_cls, w_id_rs1, w_id_rs2, w_mem_rd));
`endif

  assign w_ex_imm_i  = {{(XLEN-12){r_idex_ir[31]}}, r_idex_ir[31:20]};
  assign w_ex_imm_s  = {{(XLEN-12){r_idex_ir[31]}}, r_idex_ir[31:25], r_idex_ir[11:7]};
  assign w_ex_imm_b  = {{(XLEN-13){r_idex_ir[31]}}, r_idex_ir[31], r_idex_ir[7],
                        r_idex_ir[30:25], r_idex_ir[11:8], 1'b0};
  assign w_ex_target = r_idex_pc + w_ex_imm_b;

  // EX ALU: arithmetic wraps at XLEN, loads/stores compute their address here.
  always_comb begin
    w_ex_res = '0;
    case (w_ex_cls)
      C_LD, C_ADDI: w_ex_res = w_ex_a + w_ex_imm_i;
      C_SD:         w_ex_res = w_ex_a + w_ex_imm_s;
      C_ALU: begin
        case (r_idex_ir[14:12])
          3'b000:  w_ex_res = r_idex_ir[30] ? (w_ex_a - w_ex_b) : (w_ex_a + w_ex_b);
          3'b111:  w_ex_res = w_ex_a & w_ex_b;
          3'b110:  w_ex_res = w_ex_a | w_ex_b;
          3'b010:  w_ex_res = {{(XLEN-1){1'b0}}, ($signed(w_ex_a) < $signed(w_ex_b))};
          default: w_ex_res = '0;
        endcase
      end
      default: w_ex_res = '0;
    endcase
  end

  // A taken branch overrides any bubble request; the stalled instruction is squashed.
  assign w_flush = (w_ex_cls == C_BEQ) && (w_ex_a == w_ex_b);
  assign w_stall = w_hz && !w_flush;

  // Front end: PC, IF/ID and ID/EX with flush/stall control.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_ifid_ir <= NOP;
      r_ifid_pc <= '0;
      r_idex_ir <= NOP;
      r_idex_pc <= '0;
      r_idex_a  <= '0;
      r_idex_b  <= '0;
    end else if (w_flush) begin
      r_pc      <= w_ex_target;
      r_ifid_ir <= NOP;
      r_ifid_pc <= '0;
      r_idex_ir <= NOP;
      r_idex_pc <= '0;
      r_idex_a  <= '0;
      r_idex_b  <= '0;
    end else if (w_stall) begin
      r_idex_ir <= NOP;
      r_idex_pc <= '0;
      r_idex_a  <= '0;
      r_idex_b  <= '0;
    end else begin
      r_pc      <= r_pc + XLEN'(4);
      r_ifid_ir <= imem_data;
      r_ifid_pc <= r_pc;
      r_idex_ir <= r_ifid_ir;
      r_idex_pc <= r_ifid_pc;
      r_idex_a  <= w_id_a;
      r_idex_b  <= w_id_b;
    end
  end

  assign w_mem_val = (w_mem_cls == C_LD) ? dmem_rdata : r_exmem_alu;

  // Back end: EX/MEM and MEM/WB always advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exmem_ir    <= NOP;
      r_exmem_alu   <= '0;
      r_exmem_sdata <= '0;
      r_memwb_ir    <= NOP;
      r_memwb_val   <= '0;
    end else begin
      r_exmem_ir    <= r_idex_ir;
      r_exmem_alu   <= w_ex_res;
      r_exmem_sdata <= w_ex_b;
      r_memwb_ir    <= r_exmem_ir;
      r_memwb_val   <= w_mem_val;
    end
  end

  // Register file: reset to Regs[i]=i, written in WB, x0 never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= XLEN'(i);
    end else if (w_wb_we) begin
      r_regs[w_wb_rd] <= r_memwb_val;
    end
  end

  assign imem_addr    = r_pc;
  assign dmem_addr    = r_exmem_alu;
  assign dmem_wdata   = r_exmem_sdata;
  assign dmem_we      = (w_mem_cls == C_SD);
  assign retire_valid = w_wb_we;
  assign retire_rd    = w_wb_rd;
  assign retire_data  = r_memwb_val;
  assign stall        = w_stall;
  assign flush        = w_flush;

endmodule

// File: tb/tb_rv_pipe_hazard_cpu.sv
// Directed bench for rv_pipe_hazard_cpu (XLEN=64, RESET_PC=0).
// Stall-count expectations follow the RV_PIPE_FWD_EN build option.
module tb_rv_pipe_hazard_cpu;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef RV_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock, reset_n;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, retire_data;
  logic [31:0] imem_data;
  logic        dmem_we, retire_valid, stall, flush;
  logic [4:0]  retire_rd;

  logic [31:0] imem [256];
  logic [63:0] dmem [128];

  assign imem_data  = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[9:3]];

  rv_pipe_hazard_cpu #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
    .stall(stall), .flush(flush)
  );

  always #5 clock = ~clock;

  int          n_pass, n_fail, n_total;
  int          n_stall, n_flush, we_cnt;
  int          ret_cnt [32];
  logic [63:0] ret_val [32];
  logic [63:0] we_addr, we_data, fetch_after;
  logic        prev_flush;

  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return e_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] e_ld(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return e_i(imm, rs1, 3'b011, rd, 7'b0000011);
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold reset, clear program memory and per-test observations.
  task automatic prog_begin();
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = NOP;
    for (int i = 0; i < 32; i++) begin
      ret_cnt[i] = 0;
      ret_val[i] = '0;
    end
    n_stall = 0; n_flush = 0; we_cnt = 0;
    we_addr = '0; we_data = '0;
    fetch_after = '1; prev_flush = 1'b0;
  endtask

  task automatic prog_go();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Step n cycles, sampling outputs on the falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (prev_flush) fetch_after = imem_addr;
      prev_flush = flush;
      if (stall) n_stall++;
      if (flush) n_flush++;
      if (retire_valid) begin
        ret_cnt[retire_rd]++;
        ret_val[retire_rd] = retire_data;
      end
      if (dmem_we) begin
        we_cnt++;
        we_addr = dmem_addr;
        we_data = dmem_wdata;
      end
    end
  endtask

  initial begin
    clock = 1'b0; reset_n = 1'b1;
    n_pass = 0; n_fail = 0; n_total = 0;
    for (int i = 0; i < 128; i++) dmem[i] = '0;

    // Asynchronous reset before any clock edge
    prog_begin();
    #3;
    check("rst_pc", imem_addr, 64'h0);
    check("rst_we", {63'b0, dmem_we}, 64'h0);
    check("rst_retire", {63'b0, retire_valid}, 64'h0);
    check("rst_stall", {63'b0, stall}, 64'h0);
    check("rst_flush", {63'b0, flush}, 64'h0);

    // ADDI x5,x0,7 ; ADD x6,x5,x5
    imem[0] = e_addi(5'd5, 5'd0, 12'd7);
    imem[1] = e_r(7'b0000000, 3'b000, 5'd6, 5'd5, 5'd5);
    prog_go();
    run(14);
    check("raw_x5", ret_val[5], 64'd7);
    check("raw_x6", ret_val[6], 64'd14);
    check("raw_x6_once", 64'(ret_cnt[6]), 64'd1);
    check("raw_stalls", 64'(n_stall), FWD ? 64'd0 : 64'd2);

    // Load-use: Mem[0x10]=0x1234 ; LD x7,0x10(x0) ; ADD x8,x7,x1
    prog_begin();
    dmem[2] = 64'h1234;
    imem[0] = e_ld(5'd7, 5'd0, 12'h010);
    imem[1] = e_r(7'b0000000, 3'b000, 5'd8, 5'd7, 5'd1);
    prog_go();
    run(14);
    check("ld_x7", ret_val[7], 64'h1234);
    check("ld_x8", ret_val[8], 64'h1235);
    check("ld_stalls", 64'(n_stall), FWD ? 64'd1 : 64'd2);

    // Taken BEQ +8: ADDI x9 squashed, target refetched
    prog_begin();
    imem[0] = e_beq(5'd1, 5'd1, 13'd8);
    imem[1] = e_addi(5'd9, 5'd0, 12'd1);
    imem[2] = e_addi(5'd10, 5'd0, 12'd3);
    prog_go();
    run(14);
    check("beq_flushes", 64'(n_flush), 64'd1);
    check("beq_x9_never", 64'(ret_cnt[9]), 64'd0);
    check("beq_x10_once", 64'(ret_cnt[10]), 64'd1);
    check("beq_fetch", fetch_after, 64'h8);

    // Taken BEQ +16: both shadow instructions squashed
    prog_begin();
    imem[0] = e_beq(5'd1, 5'd1, 13'd16);
    imem[1] = e_addi(5'd13, 5'd0, 12'd1);
    imem[2] = e_addi(5'd14, 5'd0, 12'd2);
    imem[4] = e_addi(5'd12, 5'd0, 12'd6);
    prog_go();
    run(14);
    check("beq16_fetch", fetch_after, 64'h10);
    check("beq16_x13", 64'(ret_cnt[13]), 64'd0);
    check("beq16_x14", 64'(ret_cnt[14]), 64'd0);
    check("beq16_x12", ret_val[12], 64'd6);

    // Not-taken BEQ x1,x2 (1 != 2)
    prog_begin();
    imem[0] = e_beq(5'd1, 5'd2, 13'd8);
    imem[1] = e_addi(5'd11, 5'd0, 12'd4);
    prog_go();
    run(12);
    check("bnt_flushes", 64'(n_flush), 64'd0);
    check("bnt_x11", ret_val[11], 64'd4);

    // ALU ops on reset register values (x3=3, x5=5)
    prog_begin();
    imem[0] = e_r(7'b0100000, 3'b000, 5'd15, 5'd3, 5'd5);
    imem[1] = e_r(7'b0000000, 3'b111, 5'd16, 5'd3, 5'd5);
    imem[2] = e_r(7'b0000000, 3'b110, 5'd17, 5'd3, 5'd5);
    imem[3] = e_r(7'b0000000, 3'b010, 5'd18, 5'd3, 5'd5);
    imem[4] = e_r(7'b0000000, 3'b010, 5'd19, 5'd5, 5'd3);
    imem[5] = e_addi(5'd20, 5'd0, 12'hfff);
    prog_go();
    run(16);
    check("alu_sub", ret_val[15], 64'hffff_ffff_ffff_fffe);
    check("alu_and", ret_val[16], 64'd1);
    check("alu_or", ret_val[17], 64'd7);
    check("alu_slt_t", ret_val[18], 64'd1);
    check("alu_slt_f", 64'(ret_cnt[19]) + ret_val[19], 64'd1);
    check("alu_addi_neg", ret_val[20], 64'hffff_ffff_ffff_ffff);

    // Store with forwarded data: ADDI x4,x0,0x55 ; SD x4,0x20(x0)
    prog_begin();
    imem[0] = e_addi(5'd4, 5'd0, 12'h055);
    imem[1] = e_sd(5'd4, 5'd0, 12'h020);
    prog_go();
    run(14);
    check("sd_we_cnt", 64'(we_cnt), 64'd1);
    check("sd_addr", we_addr, 64'h20);
    check("sd_wdata", we_data, 64'h55);
    check("sd_stalls", 64'(n_stall), FWD ? 64'd0 : 64'd2);

    // x0 hardwired: ADDI x0,x0,5 ; ADD x3,x0,x0
    prog_begin();
    imem[0] = e_addi(5'd0, 5'd0, 12'd5);
    imem[1] = e_r(7'b0000000, 3'b000, 5'd3, 5'd0, 5'd0);
    prog_go();
    run(12);
    check("x0_x3_val", ret_val[3], 64'd0);
    check("x0_x3_once", 64'(ret_cnt[3]), 64'd1);
    check("x0_no_retire", 64'(ret_cnt[0]), 64'd0);

    // Reset while SD x2,0x28(x0) sits in EX
    prog_begin();
    imem[0] = e_sd(5'd2, 5'd0, 12'h028);
    prog_go();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("mid_pc_before", imem_addr, 64'h8);
    reset_n = 1'b0;
    #1;
    check("mid_pc", imem_addr, 64'h0);
    check("mid_we", {63'b0, dmem_we}, 64'h0);
    check("mid_retire", {63'b0, retire_valid}, 64'h0);
    check("mid_stall_flush", {62'b0, stall, flush}, 64'h0);
    run(4);
    check("mid_no_store", 64'(we_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls on an event.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
